// File: rtl/l15_anycore_resp_queue.sv
// L1.5 return-packet queue: buffers returns, decodes them into anycore I-fill,
// D-fill, store-complete and wakeup events, and tracks outstanding loads/stores.
module l15_anycore_resp_queue #(
    parameter int unsigned PADDR_W       = 40,
    parameter int unsigned IC_TAG_BITS   = 24,
    parameter int unsigned IC_INDEX_BITS = 8,
    parameter int unsigned IC_LINE_BITS  = 256,
    parameter int unsigned DC_TAG_BITS   = 24,
    parameter int unsigned DC_INDEX_BITS = 8,
    parameter int unsigned DC_LINE_BITS  = 128,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned MAX_ST        = 2,
    parameter int unsigned MAX_LD        = 1,
    parameter int unsigned BYTE_SWAP     = 1,
    parameter int unsigned INT_PULSE     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     l15_val,
    input  logic [3:0]               l15_returntype,
    input  logic [PADDR_W-1:0]       l15_address,
    input  logic [63:0]              l15_data_0,
    input  logic [63:0]              l15_data_1,
    input  logic [63:0]              l15_data_2,
    input  logic [63:0]              l15_data_3,
    output logic                     l15_req_ack,
    output logic [IC_TAG_BITS-1:0]   mem2ic_tag,
    output logic [IC_INDEX_BITS-1:0] mem2ic_index,
    output logic [IC_LINE_BITS-1:0]  mem2ic_data,
    output logic                     mem2ic_respvalid,
    input  logic                     ic2mem_fill_rdy,
    input  logic                     dc2mem_ldvalid,
    output logic [DC_TAG_BITS-1:0]   mem2dc_ldtag,
    output logic [DC_INDEX_BITS-1:0] mem2dc_ldindex,
    output logic [DC_LINE_BITS-1:0]  mem2dc_lddata,
    output logic                     mem2dc_ldvalid,
    input  logic                     dc2mem_stvalid,
    output logic                     mem2dc_stcomplete,
    output logic                     mem2dc_ststall,
    output logic                     anycore_int,
    output logic                     proto_err
);

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] INT_RET   = 4'b0111;

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ST_W  = $clog2(MAX_ST + 1);
    localparam int unsigned LD_W  = $clog2(MAX_LD + 1);
    localparam int unsigned PC_W  = $clog2(INT_PULSE + 1);

    typedef struct packed {
        logic [3:0]         rtype;
        logic               wake;
        logic [PADDR_W-1:0] addr;
        logic [255:0]       data;
    } entry_t;

    entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, rptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ST_W-1:0]    st_q, st_d;
    logic [LD_W-1:0]    ld_q, ld_d;
    logic [PC_W-1:0]    pulse_q, pulse_d;
    logic               err_q, err_d;
    logic               int_q;
    logic               full, head_v, push, pop, int_trig;
    entry_t             push_e, head;
    logic [63:0]        addr64;
    logic               unused_c;

    function automatic logic [63:0] swap64(input logic [63:0] w);
        logic [63:0] r;
        r = w;
        if (BYTE_SWAP != 0) begin
            for (int b = 0; b < 8; b++) r[8*b +: 8] = w[8*(7-b) +: 8];
        end
        return r;
    endfunction

    // Accept side: no bypass, a full queue refuses even when the head pops.
    assign full        = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign head_v      = (cnt_q != '0);
    assign l15_req_ack = l15_val & ~full;
    assign push        = l15_req_ack;
    assign head        = fifo_q[rptr_q];

    always_comb begin
        push_e       = '0;
        push_e.rtype = l15_returntype;
        push_e.wake  = (l15_data_0[17:16] == 2'b01);
        push_e.addr  = l15_address;
        push_e.data  = {swap64(l15_data_3), swap64(l15_data_2),
                        swap64(l15_data_1), swap64(l15_data_0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[PTR_W'(i)] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= push_e;
                wptr_q         <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (!push && pop) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Head decode; an I-fill the cache cannot take blocks the whole queue.
    always_comb begin
        pop               = 1'b0;
        int_trig          = 1'b0;
        mem2ic_respvalid  = 1'b0;
        mem2dc_ldvalid    = 1'b0;
        mem2dc_stcomplete = 1'b0;
        if (head_v) begin
            case (head.rtype)
                IFILL_RET: begin
                    mem2ic_respvalid = ic2mem_fill_rdy;
                    pop              = ic2mem_fill_rdy;
                end
                LOAD_RET: begin
                    mem2dc_ldvalid = 1'b1;
                    pop            = 1'b1;
                end
                ST_ACK: begin
                    mem2dc_stcomplete = 1'b1;
                    pop               = 1'b1;
                end
                INT_RET: begin
                    int_trig = head.wake;
                    pop      = 1'b1;
                end
                default: pop = 1'b1;
            endcase
        end
    end

    assign addr64         = 64'($signed(head.addr));
    assign mem2ic_tag     = addr64[63 -: IC_TAG_BITS];
    assign mem2ic_index   = addr64[63-IC_TAG_BITS -: IC_INDEX_BITS];
    assign mem2ic_data    = head.data[IC_LINE_BITS-1:0];
    assign mem2dc_ldtag   = addr64[63 -: DC_TAG_BITS];
    assign mem2dc_ldindex = addr64[63-DC_TAG_BITS -: DC_INDEX_BITS];
    assign mem2dc_lddata  = head.data[DC_LINE_BITS-1:0];
    assign unused_c       = ^{addr64, head.data};

    assign mem2dc_ststall = (st_q == ST_W'(MAX_ST)) | (ld_q == LD_W'(MAX_LD)) |
                            (ld_q != '0) | dc2mem_ldvalid | dc2mem_stvalid;

    // Outstanding counters saturate and flag a protocol error on misuse.
    always_comb begin
        st_d    = st_q;
        ld_d    = ld_q;
        err_d   = err_q;
        pulse_d = (pulse_q != '0) ? pulse_q - PC_W'(1) : '0;
        if (dc2mem_stvalid && !mem2dc_stcomplete) begin
            if (st_q == ST_W'(MAX_ST)) err_d = 1'b1;
            else                       st_d  = st_q + ST_W'(1);
        end else if (!dc2mem_stvalid && mem2dc_stcomplete) begin
            if (st_q == '0) err_d = 1'b1;
            else            st_d  = st_q - ST_W'(1);
        end
        if (dc2mem_ldvalid && !mem2dc_ldvalid) begin
            if (ld_q == LD_W'(MAX_LD)) err_d = 1'b1;
            else                       ld_d  = ld_q + LD_W'(1);
        end else if (!dc2mem_ldvalid && mem2dc_ldvalid) begin
            if (ld_q == '0) err_d = 1'b1;
            else            ld_d  = ld_q - LD_W'(1);
        end
        if (int_trig) pulse_d = PC_W'(INT_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
            pulse_q <= '0;
            int_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
            int_q   <= (pulse_d != '0);
        end
    end

    assign proto_err   = err_q;
    assign anycore_int = int_q;

endmodule

// File: tb/tb_l15_anycore_resp_queue.sv
// Directed bench for l15_anycore_resp_queue with hand-computed expectations.
module tb_l15_anycore_resp_queue;

    localparam logic [3:0] LOAD_RET  = 4'b0000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] ST_ACK    = 4'b0100;
    localparam logic [3:0] INT_RET   = 4'b0111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         l15_val;
    logic [3:0]   l15_returntype;
    logic [39:0]  l15_address;
    logic [63:0]  l15_data_0, l15_data_1, l15_data_2, l15_data_3;
    logic         l15_req_ack;
    logic [23:0]  mem2ic_tag;
    logic [7:0]   mem2ic_index;
    logic [255:0] mem2ic_data;
    logic         mem2ic_respvalid;
    logic         ic2mem_fill_rdy;
    logic         dc2mem_ldvalid;
    logic [23:0]  mem2dc_ldtag;
    logic [7:0]   mem2dc_ldindex;
    logic [127:0] mem2dc_lddata;
    logic         mem2dc_ldvalid;
    logic         dc2mem_stvalid;
    logic         mem2dc_stcomplete;
    logic         mem2dc_ststall;
    logic         anycore_int;
    logic         proto_err;

    int checks = 0;
    int errors = 0;

    l15_anycore_resp_queue #(.INT_PULSE(3)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .l15_val           (l15_val),
        .l15_returntype    (l15_returntype),
        .l15_address       (l15_address),
        .l15_data_0        (l15_data_0),
        .l15_data_1        (l15_data_1),
        .l15_data_2        (l15_data_2),
        .l15_data_3        (l15_data_3),
        .l15_req_ack       (l15_req_ack),
        .mem2ic_tag        (mem2ic_tag),
        .mem2ic_index      (mem2ic_index),
        .mem2ic_data       (mem2ic_data),
        .mem2ic_respvalid  (mem2ic_respvalid),
        .ic2mem_fill_rdy   (ic2mem_fill_rdy),
        .dc2mem_ldvalid    (dc2mem_ldvalid),
        .mem2dc_ldtag      (mem2dc_ldtag),
        .mem2dc_ldindex    (mem2dc_ldindex),
        .mem2dc_lddata     (mem2dc_lddata),
        .mem2dc_ldvalid    (mem2dc_ldvalid),
        .dc2mem_stvalid    (dc2mem_stvalid),
        .mem2dc_stcomplete (mem2dc_stcomplete),
        .mem2dc_ststall    (mem2dc_ststall),
        .anycore_int       (anycore_int),
        .proto_err         (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic pkt(input logic [3:0] t, input logic [39:0] a,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2, input logic [63:0] d3);
        l15_val        = 1'b1;
        l15_returntype = t;
        l15_address    = a;
        l15_data_0     = d0;
        l15_data_1     = d1;
        l15_data_2     = d2;
        l15_data_3     = d3;
    endtask

    initial begin
        rst_n = 1'b0;
        l15_val = 1'b0; l15_returntype = '0; l15_address = '0;
        l15_data_0 = '0; l15_data_1 = '0; l15_data_2 = '0; l15_data_3 = '0;
        ic2mem_fill_rdy = 1'b0; dc2mem_ldvalid = 1'b0; dc2mem_stvalid = 1'b0;

        // reset state
        mid();
        chk("rst_respvalid", mem2ic_respvalid, 0);
        chk("rst_ldvalid", mem2dc_ldvalid, 0);
        chk("rst_stcomplete", mem2dc_stcomplete, 0);
        chk("rst_ststall", mem2dc_ststall, 0);
        chk("rst_int", anycore_int, 0);
        chk("rst_proto_err", proto_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single I-fill, byte-swapped, one-cycle latency
        ic2mem_fill_rdy = 1'b1;
        pkt(IFILL_RET, 40'h80_0000_1040, 64'h0011223344556677, 64'h8899AABBCCDDEEFF,
            64'h0102030405060708, 64'h1112131415161718);
        mid();
        chk("if1_ack", l15_req_ack, 1);
        chk("if1_valid_n", mem2ic_respvalid, 0);
        tick();
        l15_val = 1'b0;
        mid();
        chk("if1_valid", mem2ic_respvalid, 1);
        chk("if1_data_lo", mem2ic_data[63:0], 64'h7766554433221100);
        chk("if1_data", mem2ic_data, {64'h1817161514131211, 64'h0807060504030201,
                                      64'hFFEEDDCCBBAA9988, 64'h7766554433221100});
        chk("if1_tag", mem2ic_tag, 24'hFFFFFF);
        chk("if1_index", mem2ic_index, 8'h80);
        tick();
        mid();
        chk("if1_valid_after", mem2ic_respvalid, 0);
        tick();

        // fill backpressure: four fills fill the queue, fifth refused
        ic2mem_fill_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pkt(IFILL_RET, {8'(i), 32'h0}, 64'(i), 0, 0, 0);
            mid();
            chk($sformatf("bp_ack%0d", i), l15_req_ack, (i < 4) ? 1 : 0);
            chk($sformatf("bp_hold%0d", i), mem2ic_respvalid, 0);
            tick();
        end
        pkt(4'hF, 40'h0, 0, 0, 0, 0);
        ic2mem_fill_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            if (k == 0) chk("bp_full_pop_ack", l15_req_ack, 0);
            chk($sformatf("bp_drain%0d", k), mem2ic_respvalid, 1);
            chk($sformatf("bp_index%0d", k), mem2ic_index, 8'(k));
            tick();
            l15_val = 1'b0;
        end
        mid();
        chk("bp_drained", mem2ic_respvalid, 0);
        pkt(4'hF, 40'h0, 0, 0, 0, 0);
        mid();
        chk("bp_ack_resume", l15_req_ack, 1);
        tick();
        l15_val = 1'b0;
        mid();
        chk("odd_no_ic", mem2ic_respvalid, 0);
        chk("odd_no_ld", mem2dc_ldvalid, 0);
        chk("odd_no_st", mem2dc_stcomplete, 0);
        tick();

        // load outstanding then fill three cycles later
        dc2mem_ldvalid = 1'b1;
        mid();
        chk("ld_stall_issue", mem2dc_ststall, 1);
        tick();
        dc2mem_ldvalid = 1'b0;
        mid();
        chk("ld_stall_wait1", mem2dc_ststall, 1);
        tick();
        mid();
        chk("ld_stall_wait2", mem2dc_ststall, 1);
        tick();
        pkt(LOAD_RET, 40'h12_3456_789A, 64'h0102030405060708, 64'hA0B0C0D0E0F00010, 0, 0);
        mid();
        chk("ld_stall_wait3", mem2dc_ststall, 1);
        chk("ld_valid_n", mem2dc_ldvalid, 0);
        tick();
        l15_val = 1'b0;
        mid();
        chk("ld_valid", mem2dc_ldvalid, 1);
        chk("ld_data", mem2dc_lddata, {64'h1000F0E0D0C0B0A0, 64'h0807060504030201});
        chk("ld_tag", mem2dc_ldtag, 24'h000000);
        chk("ld_index", mem2dc_ldindex, 8'h12);
        chk("ld_stall_fill", mem2dc_ststall, 1);
        tick();
        mid();
        chk("ld_stall_clear", mem2dc_ststall, 0);
        chk("ld_no_err", proto_err, 0);
        tick();

        // two stores, overflow store, then one ack
        dc2mem_stvalid = 1'b1;
        tick();
        tick();
        dc2mem_stvalid = 1'b0;
        mid();
        chk("st_stall_full", mem2dc_ststall, 1);
        chk("st_no_err", proto_err, 0);
        tick();
        dc2mem_stvalid = 1'b1;
        tick();
        dc2mem_stvalid = 1'b0;
        mid();
        chk("st_overflow_err", proto_err, 1);
        chk("st_stall_sat", mem2dc_ststall, 1);
        tick();
        pkt(ST_ACK, 40'h0, 0, 0, 0, 0);
        tick();
        l15_val = 1'b0;
        mid();
        chk("st_complete", mem2dc_stcomplete, 1);
        tick();
        mid();
        chk("st_complete_pulse", mem2dc_stcomplete, 0);
        chk("st_cnt_one", mem2dc_ststall, 0);
        chk("st_err_sticky", proto_err, 1);
        tick();

        // wakeup interrupt: three-cycle pulse starting two cycles after accept
        pkt(INT_RET, 40'h0, 64'h0000_0000_0001_0000, 0, 0, 0);
        tick();
        l15_val = 1'b0;
        mid();
        chk("int_n1", anycore_int, 0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            mid();
            chk($sformatf("int_n%0d", c), anycore_int, (c <= 4) ? 1 : 0);
        end
        tick();
        pkt(INT_RET, 40'h0, 64'h0000_0000_0002_0000, 0, 0, 0);
        tick();
        l15_val = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mid();
            chk($sformatf("int_none%0d", c), anycore_int, 0);
            tick();
        end

        // asynchronous reset with queued fills and one store outstanding
        ic2mem_fill_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pkt(IFILL_RET, 40'h0, 64'(i), 0, 0, 0);
            tick();
        end
        l15_val = 1'b0;
        #2;
        ic2mem_fill_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_respvalid", mem2ic_respvalid, 0);
        chk("arst_proto_err", proto_err, 0);
        chk("arst_int", anycore_int, 0);
        chk("arst_ststall", mem2dc_ststall, 0);
        tick();
        rst_n = 1'b1;
        mid();
        chk("post_rst_empty", mem2ic_respvalid, 0);
        chk("post_rst_ststall", mem2dc_ststall, 0);
        tick();
        pkt(IFILL_RET, 40'h0, 0, 0, 0, 0);
        mid();
        chk("post_rst_ack", l15_req_ack, 1);
        tick();
        l15_val = 1'b0;
        mid();
        chk("post_rst_fill", mem2ic_respvalid, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
